// File: rtl/axis_readback_checker.sv
// Avalon-MM burst read checker: streams an incrementing pattern back,
// counts mismatches and tracks latency, beats and read-data timeouts.
module axis_readback_checker #(
  parameter int data_width        = 128,
  parameter int address_width     = 27,
  parameter int burstcount_width  = 7,
  parameter int byte_enable_width = data_width / 8
) (
  input  logic                         user_clk,
  input  logic                         user_resetn,
  input  logic                         start,
  input  logic [address_width-1:0]     base_address,
  input  logic [15:0]                  num_bursts,
  input  logic [burstcount_width-1:0]  burst_len,
  input  logic [10:0]                  seed,
  input  logic                         amm_ready,
  output logic                         amm_read,
  output logic [address_width-1:0]     amm_address,
  output logic [burstcount_width-1:0]  amm_burstcount,
  output logic [byte_enable_width-1:0] amm_byteenable,
  input  logic [data_width-1:0]        amm_readdata,
  input  logic                         amm_readdatavalid,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [15:0]                  error_count,
  output logic [address_width-1:0]     first_error_addr,
  output logic [7:0]                   latency_max,
  output logic [31:0]                  beats_received
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_DATA, DONE, TIMEOUT
  } state_t;

  state_t state, state_nx;

  logic [1:0]                  rst_sync;
  logic                        rst_n;
  logic [15:0]                 bursts_left;
  logic [burstcount_width-1:0] beat_cnt;
  logic [10:0]                 exp_val;
  logic [9:0]                  to_cnt;
  logic [7:0]                  lat_cnt;
  logic                        first_pend;
  logic                        err_seen;
  logic                        launch;
  logic                        accept;
  logic                        in_wait;
  logic                        beat;
  logic                        last_beat;
  logic                        mismatch;
  logic                        expired;

  // assert asynchronously, release on a clock edge
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) rst_sync <= '0;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign launch    = start & ~busy;
  assign accept    = amm_read & amm_ready;
  assign in_wait   = state == WAIT_DATA;
  assign beat      = in_wait & amm_readdatavalid;
  assign last_beat = beat &
    (beat_cnt == amm_burstcount - burstcount_width'(1));
  assign mismatch  = amm_readdata != data_width'(exp_val);
  assign expired   = in_wait & ~amm_readdatavalid &
                     (to_cnt == 10'd1022);

  assign amm_read       = state == ISSUE;
  assign busy           = (state == ISSUE) | in_wait;
  assign done           = (state == DONE) | (state == TIMEOUT);
  assign timeout        = state == TIMEOUT;
  assign amm_byteenable = '1;

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, TIMEOUT:
        if (start) begin
          if (num_bursts == '0 || burst_len == '0)
            state_nx = DONE;
          else
            state_nx = ISSUE;
        end
      ISSUE:
        if (amm_ready) state_nx = WAIT_DATA;
      WAIT_DATA:
        if (last_beat) begin
          if (bursts_left == 16'd1) state_nx = DONE;
          else                      state_nx = ISSUE;
        end else if (expired) begin
          state_nx = TIMEOUT;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      amm_address      <= '0;
      amm_burstcount   <= '0;
      bursts_left      <= '0;
      beat_cnt         <= '0;
      exp_val          <= '0;
      to_cnt           <= '0;
      lat_cnt          <= '0;
      first_pend       <= 1'b0;
      err_seen         <= 1'b0;
      error_count      <= '0;
      first_error_addr <= '0;
      latency_max      <= '0;
      beats_received   <= '0;
    end else if (launch) begin
      amm_address      <= base_address;
      amm_burstcount   <= burst_len;
      bursts_left      <= num_bursts;
      beat_cnt         <= '0;
      exp_val          <= seed;
      to_cnt           <= '0;
      lat_cnt          <= '0;
      first_pend       <= 1'b0;
      err_seen         <= 1'b0;
      error_count      <= '0;
      first_error_addr <= '0;
      latency_max      <= '0;
      beats_received   <= '0;
    end else begin
      if (accept) begin
        beat_cnt   <= '0;
        to_cnt     <= '0;
        lat_cnt    <= '0;
        first_pend <= 1'b1;
      end
      if (in_wait && first_pend && lat_cnt != 8'hFF)
        lat_cnt <= lat_cnt + 8'd1;
      if (in_wait && !amm_readdatavalid)
        to_cnt <= to_cnt + 10'd1;
      if (beat) begin
        to_cnt         <= '0;
        exp_val        <= exp_val + 11'd1;
        beats_received <= beats_received + 32'd1;
        beat_cnt       <= beat_cnt + burstcount_width'(1);
        if (first_pend) begin
          first_pend <= 1'b0;
          if (lat_cnt > latency_max) latency_max <= lat_cnt;
        end
        if (mismatch) begin
          if (error_count != 16'hFFFF)
            error_count <= error_count + 16'd1;
          if (!err_seen) begin
            err_seen         <= 1'b1;
            first_error_addr <= amm_address;
          end
        end
      end
      if (last_beat) begin
        beat_cnt    <= '0;
        bursts_left <= bursts_left - 16'd1;
        if (bursts_left != 16'd1)
          amm_address <= amm_address +
                         address_width'(amm_burstcount);
      end
    end
  end

endmodule

// File: tb/tb_axis_readback_checker.sv
// Scoreboard bench for axis_readback_checker: request addresses are
// queued at start and popped as the DUT issues each burst.
module tb_axis_readback_checker;

  localparam int DW = 128;
  localparam int AW = 27;
  localparam int BW = 7;
  localparam int EW = DW / 8;

  logic          user_clk;
  logic          user_resetn;
  logic          start;
  logic [AW-1:0] base_address;
  logic [15:0]   num_bursts;
  logic [BW-1:0] burst_len;
  logic [10:0]   seed;
  logic          amm_ready;
  logic          amm_read;
  logic [AW-1:0] amm_address;
  logic [BW-1:0] amm_burstcount;
  logic [EW-1:0] amm_byteenable;
  logic [DW-1:0] amm_readdata;
  logic          amm_readdatavalid;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [15:0]   error_count;
  logic [AW-1:0] first_error_addr;
  logic [7:0]    latency_max;
  logic [31:0]   beats_received;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];

  axis_readback_checker dut (
    .user_clk          (user_clk),
    .user_resetn       (user_resetn),
    .start             (start),
    .base_address      (base_address),
    .num_bursts        (num_bursts),
    .burst_len         (burst_len),
    .seed              (seed),
    .amm_ready         (amm_ready),
    .amm_read          (amm_read),
    .amm_address       (amm_address),
    .amm_burstcount    (amm_burstcount),
    .amm_byteenable    (amm_byteenable),
    .amm_readdata      (amm_readdata),
    .amm_readdatavalid (amm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .timeout           (timeout),
    .error_count       (error_count),
    .first_error_addr  (first_error_addr),
    .latency_max       (latency_max),
    .beats_received    (beats_received)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [10:0] s,
                                        input int n);
    logic [10:0] v;
    v = s + n[10:0];
    return DW'(v);
  endfunction

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_read"}, amm_read, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tmo"}, timeout, 0);
    check({tag, "_addr"}, amm_address, 0);
    check({tag, "_bc"}, amm_burstcount, 0);
    check({tag, "_be"}, amm_byteenable, {EW{1'b1}});
    check({tag, "_errs"}, error_count, 0);
    check({tag, "_ferr"}, first_error_addr, 0);
    check({tag, "_lat"}, latency_max, 0);
    check({tag, "_beats"}, beats_received, 0);
  endtask

  task automatic check_stats(input string tag, input int beats,
                             input int errs,
                             input logic [AW-1:0] ferr,
                             input int lat);
    check({tag, "_beats"}, beats_received, beats);
    check({tag, "_errs"}, error_count, errs);
    check({tag, "_ferr"}, first_error_addr, ferr);
    check({tag, "_lat"}, latency_max, lat > 255 ? 255 : lat);
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 2000) begin
      tick();
      c++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic start_run(input logic [AW-1:0] base,
                           input int nb, input int bl,
                           input logic [10:0] sd);
    base_address = base;
    num_bursts   = 16'(nb);
    burst_len    = BW'(bl);
    seed         = sd;
    for (int i = 0; i < nb && bl > 0; i++)
      exp_q.push_back(base + AW'(i * bl));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // memory model: stall, then return the pattern after lat idle cycles
  task automatic do_run(input logic [AW-1:0] base,
                        input int nb, input int bl,
                        input logic [10:0] sd,
                        input int lat, input int stall,
                        input int corrupt, input bit respond,
                        input bit poke);
    int n;
    int wc;
    int bad;
    logic [AW-1:0] a;
    start_run(base, nb, bl, sd);
    n = 0;
    for (int i = 0; i < nb && bl > 0; i++) begin
      wc = 0;
      while (!amm_read && wc < 64) begin
        tick();
        wc++;
      end
      if (!amm_read) begin
        check("req_seen", amm_read, 1);
        return;
      end
      a = exp_q.pop_front();
      check("req_addr", amm_address, a);
      check("req_len", amm_burstcount, bl);
      check("req_be", amm_byteenable, {EW{1'b1}});
      bad = 0;
      repeat (stall) begin
        tick();
        if (amm_read !== 1'b1 || amm_address !== a ||
            amm_burstcount !== BW'(bl))
          bad++;
      end
      if (stall > 0) check("req_stable", bad, 0);
      amm_ready = 1'b1;
      tick();
      amm_ready = 1'b0;
      check("one_outstanding", amm_read, 0);
      if (!respond) return;
      for (int j = 0; j < lat; j++) begin
        tick();
        if (poke && i == 0 && j == 0) begin
          base_address = '0;
          num_bursts   = 16'd1;
          start        = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      for (int b = 0; b < bl; b++) begin
        amm_readdatavalid = 1'b1;
        amm_readdata      = pat(sd, n);
        if (n == corrupt) amm_readdata[100] = 1'b1;
        tick();
        n++;
      end
      amm_readdatavalid = 1'b0;
      amm_readdata      = '0;
    end
  endtask

  task automatic stray(input int cycles);
    amm_readdatavalid = 1'b1;
    amm_readdata      = pat(11'd0, 0);
    repeat (cycles) tick();
    amm_readdatavalid = 1'b0;
    amm_readdata      = '0;
  endtask

  initial begin
    int bad;
    user_resetn       = 1'b0;
    start             = 1'b0;
    base_address      = '0;
    num_bursts        = '0;
    burst_len         = '0;
    seed              = '0;
    amm_ready         = 1'b0;
    amm_readdata      = '0;
    amm_readdatavalid = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    user_resetn = 1'b1;
    repeat (4) tick();

    stray(3);
    check("idle_stray_beats", beats_received, 0);
    check("idle_stray_busy", busy, 0);

    do_run(27'h100, 4, 8, 11'd0, 5, 0, -1, 1, 1);
    wait_done("happy");
    check("happy_tmo", timeout, 0);
    check_stats("happy", 32, 0, 0, 5);
    check("happy_sb_empty", exp_q.size(), 0);

    stray(3);
    check("done_stray_beats", beats_received, 32);
    check("done_hold", done, 1);

    start_run(27'h300, 0, 8, 11'd0);
    bad = 0;
    repeat (6) begin
      if (amm_read) bad++;
      tick();
    end
    check("nb0_no_read", bad, 0);
    check("nb0_done", done, 1);
    check("nb0_beats", beats_received, 0);

    start_run(27'h300, 3, 0, 11'd0);
    bad = 0;
    repeat (6) begin
      if (amm_read) bad++;
      tick();
    end
    check("bl0_no_read", bad, 0);
    check("bl0_done", done, 1);

    do_run(27'h100, 4, 8, 11'd0, 5, 0, 11, 1, 0);
    wait_done("corrupt");
    check_stats("corrupt", 32, 1, 27'h108, 5);

    do_run(27'h20, 2, 3, 11'h7FE, 2, 0, -1, 1, 0);
    wait_done("seedwrap");
    check_stats("seedwrap", 6, 0, 0, 2);

    do_run(27'h7FFFFFC, 2, 8, 11'd0, 3, 7, -1, 1, 0);
    wait_done("wrap");
    check_stats("wrap", 16, 0, 0, 3);
    check("wrap_sb_empty", exp_q.size(), 0);

    do_run(27'h40, 1, 1, 11'd5, 1022, 0, -1, 1, 0);
    wait_done("edge1023");
    check("edge1023_tmo", timeout, 0);
    check_stats("edge1023", 1, 0, 0, 1022);

    do_run(27'h200, 1, 4, 11'd0, 0, 0, -1, 0, 0);
    repeat (1022) tick();
    check("tmo_early", timeout, 0);
    check("tmo_early_busy", busy, 1);
    tick();
    check("tmo_flag", timeout, 1);
    check("tmo_done", done, 1);
    check("tmo_busy", busy, 0);
    check("tmo_beats", beats_received, 0);
    repeat (5) tick();
    check("tmo_hold", timeout, 1);

    do_run(27'h100, 2, 8, 11'd0, 0, 0, -1, 0, 0);
    repeat (3) tick();
    check("midrst_busy", busy, 1);
    user_resetn = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    amm_readdatavalid = 1'b1;
    amm_readdata      = pat(11'd0, 0);
    repeat (2) tick();
    user_resetn = 1'b1;
    repeat (4) tick();
    amm_readdatavalid = 1'b0;
    amm_readdata      = '0;
    check("postrst_beats", beats_received, 0);
    check("postrst_read", amm_read, 0);

    do_run(27'h100, 4, 8, 11'd0, 5, 0, -1, 1, 0);
    wait_done("rerun");
    check_stats("rerun", 32, 0, 0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_readback_checker.md
AXIS_READBACK_CHECKER -- requirements
Module: axis_readback_checker

Interface
REQ-001 Parameters SHALL be:
- data_width, 128, Avalon read data width
- address_width, 27, Avalon word address width
- burstcount_width, 7, Avalon burstcount width
- byte_enable_width, data_width/8, byteenable width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- user_clk  in  1  EMIF user clock; the single clock
- user_resetn  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse that begins a check run
- base_address  in  address_width  first word address
- num_bursts  in  16  number of bursts to read
- burst_len  in  burstcount_width  beats per burst
- seed  in  11  expected value of the first beat
- amm_ready  in  1  EMIF waitrequest_n
- amm_read  out  1  read request
- amm_address  out  address_width  burst start address
- amm_burstcount  out  burstcount_width  burst length
- amm_byteenable  out  byte_enable_width  byte enables
- amm_readdata  in  data_width  read data
- amm_readdatavalid  in  1  read data qualifier
- busy  out  1  run in progress
- done  out  1  run finished; level
- timeout  out  1  run aborted on a read-data timeout
- error_count  out  16  mismatched beats; saturating
- first_error_addr  out  address_width  address of the burst holding the first mismatch
- latency_max  out  8  worst request-to-first-beat latency; saturating
- beats_received  out  32  total valid beats accepted

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT_DATA, DONE and TIMEOUT.
REQ-004 In IDLE, start=1 SHALL latch base_address, num_bursts, burst_len and seed, and clear done, timeout, error_count, first_error_addr, latency_max and beats_received.
REQ-005 From IDLE on start, if num_bursts==0 or burst_len==0 the FSM SHALL go to DONE without issuing any read; otherwise it SHALL go to ISSUE.
REQ-006 In ISSUE, amm_read SHALL be 1, amm_burstcount SHALL equal the latched burst_len, and amm_byteenable SHALL be all ones.
REQ-007 A read request is accepted in a cycle where amm_read=1 and amm_ready=1; amm_read, amm_address and amm_burstcount SHALL stay stable until acceptance, and on acceptance the FSM SHALL go to WAIT_DATA.
REQ-008 Only one burst SHALL be outstanding at a time, and amm_read SHALL be 0 outside ISSUE.
REQ-009 The next burst address SHALL be the previous address plus burst_len, modulo 2^address_width (wrap-around is permitted).
REQ-010 Expected data for beat n of the run SHALL be zero-extended (seed + n) mod 2^11, i.e. bits [10:0] carry the value and the upper bits are 0.
REQ-011 Each amm_readdatavalid=1 beat in WAIT_DATA SHALL:
- increment beats_received;
- if it mismatches the expected data, increment error_count (saturating at 0xFFFF);
- on the first mismatch of the run only, load first_error_addr with the current burst address.
REQ-012 The latency counter SHALL reset to 0 on request acceptance and increment every cycle until the first beat of the burst; on that first beat latency_max SHALL become max(latency_max, counter), with the counter saturating at 255.
REQ-013 After the last beat of a burst, the FSM SHALL go to ISSUE if bursts remain, otherwise to DONE.
REQ-014 If WAIT_DATA sees no readdatavalid for 1023 consecutive cycles, the FSM SHALL go to TIMEOUT and assert timeout.
REQ-015 busy SHALL be 1 in ISSUE and WAIT_DATA and 0 otherwise.
REQ-016 done SHALL be 1 in DONE and in TIMEOUT.
REQ-017 From DONE or TIMEOUT, start=1 SHALL begin a new run exactly as from IDLE.
REQ-018 start while busy SHALL be ignored.
REQ-019 amm_readdatavalid outside WAIT_DATA SHALL be ignored and SHALL NOT change any counter.
REQ-020 A readdatavalid beat in the same cycle the timeout count reaches 1023 SHALL win: the beat is counted and no timeout occurs.
REQ-021 Statistic outputs SHALL hold their values in DONE and TIMEOUT until the next start.

Reset
REQ-022 user_resetn=0 SHALL asynchronously force:
- state to IDLE;
- amm_read, busy, done and timeout to 0;
- amm_address, amm_burstcount, error_count, first_error_addr, latency_max, beats_received and all internal counters to 0;
- amm_byteenable to all ones.
REQ-023 Reset mid-run SHALL abandon the run with no further requests, and read data arriving after reset release SHALL be ignored per REQ-019.
REQ-024 Reset deassertion SHALL be synchronised to user_clk so that it releases on a clock edge.

Verification
REQ-025 Happy path:
- Stimulus: base=0x100, num_bursts=4, burst_len=8, seed=0; memory model returns the matching pattern with 5-cycle latency.
- Required: requests at addresses 0x100, 0x108, 0x110, 0x118; beats_received=32; error_count=0; latency_max=5; done=1.
REQ-026 Single corruption:
- Stimulus: same as REQ-025, with beat 11 corrupted.
- Required: error_count=1; first_error_addr=0x108.
REQ-027 Backpressure and wrap:
- Stimulus: amm_ready held low for 7 cycles per request; base=0x7FFFFFC, burst_len=8, num_bursts=2.
- Required: request signals stay stable until acceptance; second address=0x0000004.
REQ-028 Timeout:
- Stimulus: memory model never returns data.
- Required: timeout=1 and done=1 exactly 1023 cycles after acceptance; busy=0.
REQ-029 Degenerate parameters:
- Stimulus: num_bursts=0.
- Required: done=1 with no amm_read pulse.
- Stimulus: stray readdatavalid while in IDLE.
- Required: beats_received unchanged.
REQ-030 Reset mid-run:
- Stimulus: user_resetn low during WAIT_DATA.
- Required: every output reaches its REQ-022 value immediately; a following start runs cleanly.
